demo_de0_sys_st_byte_serializer: RTL and testbench



---
 rtl/demo_de0_sys_st_byte_serializer.sv | 101 ++++++++++
 tb/tb_demo_de0_sys_st_byte_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_de0_sys_st_byte_serializer.sv
// ---------------------------------------------------------------------------
// demo_de0_sys_st_byte_serializer
//
// Avalon-ST width adapter: accepts one 32-bit word per handshake and emits it
// as four 8-bit symbols, most-significant byte first. Packet boundaries are
// passed through; an EOP word is truncated to (4 - in_empty) symbols.
// Sustains one symbol per clock with no bubble between consecutive words.
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   in_ready          sink ready (combinational from registered state + out_ready)
//   in_valid          upstream word valid
//   in_data           upstream word, byte 0 = [31:24]
//   in_startofpacket  word is first of packet
//   in_endofpacket    word is last of packet
//   in_empty          unused low-order bytes of an EOP word
//   out_ready         downstream ready
//   out_valid         symbol valid (registered)
//   out_data          current symbol
//   out_startofpacket symbol is first byte of packet
//   out_endofpacket   symbol is last byte of packet
// ---------------------------------------------------------------------------
module demo_de0_sys_st_byte_serializer #(
   parameter int unsigned IN_WIDTH     = 32,
   parameter int unsigned SYMBOL_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   output logic                    in_ready,
   input  logic                    in_valid,
   input  logic [IN_WIDTH-1:0]     in_data,
   input  logic                    in_startofpacket,
   input  logic                    in_endofpacket,
   input  logic [1:0]              in_empty,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [SYMBOL_WIDTH-1:0] out_data,
   output logic                    out_startofpacket,
   output logic                    out_endofpacket
);

   logic                r_hold_valid;
   logic [IN_WIDTH-1:0] r_word;
   logic                r_sop;
   logic                r_eop;
   logic [1:0]          r_byte_idx;
   logic [1:0]          r_last_idx;

   logic                w_at_last;
   logic                w_last_beat;
   logic                w_accept;

   assign w_at_last   = (r_byte_idx == r_last_idx);
   assign w_last_beat = r_hold_valid & out_ready & w_at_last;

   // Refill on the same edge the final byte leaves, so words stream gap-free.
   assign in_ready = ~r_hold_valid | w_last_beat;
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_valid <= 1'b0;
         r_word       <= '0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_byte_idx   <= 2'd0;
         r_last_idx   <= 2'd3;
      end else if (w_accept) begin
         // A load takes priority over the last-beat release.
         r_hold_valid <= 1'b1;
         r_word       <= in_data;
         r_sop        <= in_startofpacket;
         r_eop        <= in_endofpacket;
         r_byte_idx   <= 2'd0;
         // in_empty only truncates EOP words.
         r_last_idx   <= in_endofpacket ? (2'd3 - in_empty) : 2'd3;
      end else if (w_last_beat) begin
         r_hold_valid <= 1'b0;
         r_byte_idx   <= 2'd0;
      end else if (r_hold_valid && out_ready) begin
         r_byte_idx   <= r_byte_idx + 2'd1;
      end
   end

   // MSB-first symbol select.
   always_comb begin
      out_data = '0;
      unique case (r_byte_idx)
         2'd0: out_data = r_word[IN_WIDTH-1                  -: SYMBOL_WIDTH];
         2'd1: out_data = r_word[IN_WIDTH-1-SYMBOL_WIDTH     -: SYMBOL_WIDTH];
         2'd2: out_data = r_word[IN_WIDTH-1-2*SYMBOL_WIDTH   -: SYMBOL_WIDTH];
         2'd3: out_data = r_word[IN_WIDTH-1-3*SYMBOL_WIDTH   -: SYMBOL_WIDTH];
      endcase
   end

   assign out_valid         = r_hold_valid;
   assign out_startofpacket = r_hold_valid & r_sop & (r_byte_idx == 2'd0);
   assign out_endofpacket   = r_hold_valid & r_eop & w_at_last;

endmodule

// File: tb/tb_demo_de0_sys_st_byte_serializer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for demo_de0_sys_st_byte_serializer.
// Expected symbols are pushed to a scoreboard queue when a word is accepted
// and popped whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demo_de0_sys_st_byte_serializer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_ready;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [1:0]  in_empty;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;

   always #5 clk = ~clk;

   demo_de0_sys_st_byte_serializer #(
      .IN_WIDTH     (32),
      .SYMBOL_WIDTH (8)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket)
   );

   typedef struct {
      logic [31:0] word;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic [31:0] exp_bytes;  // expected symbols, left-aligned
      int          exp_n;      // expected symbol count
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } sym_t;

   vec_t vecs[8];
   sym_t sb_q[$];

   int   n_tests = 0;
   int   n_fail  = 0;
   logic rand_rdy = 1'b0;
   logic rdy_force = 1'b1;

   // Stall-stability tracking.
   logic       st_prev = 1'b0;
   logic [7:0] st_data;
   logic       st_sop;
   logic       st_eop;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic s, input logic e, input int n);
      sym_t t;
      for (int j = 0; j < n; j++) begin
         t.data = w[31-8*j -: 8];
         t.sop  = s && (j == 0);
         t.eop  = e && (j == n - 1);
         sb_q.push_back(t);
      end
   endtask

   // Output-side checks, run at the negedge of every cycle.
   task automatic monitor();
      sym_t t;
      if (!reset_n) begin
         st_prev = 1'b0;
         return;
      end
      if (st_prev) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", {24'd0, out_data}, {24'd0, st_data});
         chk("stall_flags", {30'd0, out_startofpacket, out_endofpacket},
             {30'd0, st_sop, st_eop});
      end
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("extra_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            t = sb_q.pop_front();
            chk("byte_data", {24'd0, out_data}, {24'd0, t.data});
            chk("byte_sop", 32'(out_startofpacket), 32'(t.sop));
            chk("byte_eop", 32'(out_endofpacket), 32'(t.eop));
         end
      end
      st_prev = out_valid && !out_ready;
      st_data = out_data;
      st_sop  = out_startofpacket;
      st_eop  = out_endofpacket;
   endtask

   // One clock: sample at negedge, then re-drive out_ready just after posedge.
   task automatic tick(output logic ir);
      @(negedge clk);
      ir = in_ready;
      monitor();
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
   endtask

   task automatic send_word(input logic [31:0] w, input logic s, input logic e,
                            input logic [1:0] emp, output int waits);
      logic acc;
      logic ir;
      acc   = 1'b0;
      waits = 0;
      in_valid         = 1'b1;
      in_data          = w;
      in_startofpacket = s;
      in_endofpacket   = e;
      in_empty         = emp;
      while (!acc && waits < 200) begin
         tick(ir);
         waits++;
         if (ir) acc = 1'b1;
      end
      in_valid         = 1'b0;
      in_data          = $urandom;
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      in_empty         = 2'($urandom);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      logic ir;
      int   k;
      k = 0;
      while (sb_q.size() != 0 && k < 2000) begin
         tick(ir);
         k++;
      end
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
      tick(ir);
      chk("idle_after_drain", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int   w;
      int   n;
      logic ir;
      logic s, e;
      logic [1:0] emp;
      logic [31:0] word;
      logic bp_pat[7];
      logic bp_exp[7];

      vecs[0] = '{32'h11223344, 1'b1, 1'b1, 2'd0, 32'h11223344, 4};
      vecs[1] = '{32'hA0A1A2A3, 1'b1, 1'b0, 2'd0, 32'hA0A1A2A3, 4};
      vecs[2] = '{32'hB0B1B2B3, 1'b0, 1'b1, 2'd0, 32'hB0B1B2B3, 4};
      vecs[3] = '{32'hDEADBEEF, 1'b1, 1'b1, 2'd2, 32'hDEAD0000, 2};
      vecs[4] = '{32'hDEADBEEF, 1'b1, 1'b1, 2'd3, 32'hDE000000, 1};
      vecs[5] = '{32'hCAFEF00D, 1'b1, 1'b0, 2'd3, 32'hCAFEF00D, 4};
      vecs[6] = '{32'h12345678, 1'b0, 1'b1, 2'd1, 32'h12345600, 3};
      vecs[7] = '{32'h99887766, 1'b1, 1'b1, 2'd0, 32'h99887766, 4};

      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bp_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      reset_n          = 1'b0;
      in_valid         = 1'b0;
      in_data          = 32'd0;
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      in_empty         = 2'd0;
      out_ready        = 1'b1;

      // Reset state
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_flags", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Single word: in_ready low for 3 byte cycles, high on the 4th
      send_word(32'h11223344, 1'b1, 1'b1, 2'd0, w);
      push_word(32'h11223344, 1'b1, 1'b1, 4);
      for (int k = 0; k < 4; k++) begin
         tick(ir);
         chk("single_in_ready", 32'(ir), 32'(k == 3));
      end
      drain();

      // Table: back-to-back words; accept delay equals previous word's length
      for (int i = 0; i < 8; i++) begin
         send_word(vecs[i].word, vecs[i].sop, vecs[i].eop, vecs[i].empty, w);
         chk("table_accept_wait", 32'(w), (i == 0) ? 32'd1 : 32'(vecs[i-1].exp_n));
         push_word(vecs[i].exp_bytes, vecs[i].sop, vecs[i].eop, vecs[i].exp_n);
      end
      drain();

      // Backpressure pattern during 0x01020304
      send_word(32'h01020304, 1'b1, 1'b1, 2'd0, w);
      push_word(32'h01020304, 1'b1, 1'b1, 4);
      for (int c = 0; c < 7; c++) begin
         out_ready = bp_pat[c];
         rdy_force = bp_pat[c];
         tick(ir);
         chk("bp_in_ready", 32'(ir), 32'(bp_exp[c]));
      end
      rdy_force = 1'b1;
      out_ready = 1'b1;
      drain();

      // Reset after byte 0x22 of 0x11223344
      send_word(32'h11223344, 1'b1, 1'b1, 2'd0, w);
      push_word(32'h11223344, 1'b1, 1'b1, 4);
      tick(ir);
      tick(ir);
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_data", {24'd0, out_data}, 32'd0);
      sb_q.delete();
      tick(ir);
      reset_n = 1'b1;
      send_word(32'h55667788, 1'b1, 1'b1, 2'd0, w);
      push_word(32'h55667788, 1'b1, 1'b1, 4);
      drain();

      // Random traffic
      rand_rdy = 1'b1;
      for (int i = 0; i < 250; i++) begin
         repeat ($urandom_range(0, 2)) tick(ir);
         word = $urandom;
         s    = 1'($urandom);
         e    = 1'($urandom);
         emp  = 2'($urandom);
         n    = e ? 4 - int'(emp) : 4;
         send_word(word, s, e, emp, w);
         push_word(word, s, e, n);
      end
      drain();
      rand_rdy  = 1'b0;
      out_ready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
